// File: rtl/srff_access_arbiter.sv
// Round-robin arbiter that shares one clocked S-R flip-flop among NREQ requesters,
// producing non-overlapping S/R pulses and checking Q after each operation.
module srff_access_arbiter #(
    parameter int NREQ         = 4,
    parameter int PULSE_CYCLES = 1,
    parameter int CW           = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    input  logic            q_in,
    output logic            s_out,
    output logic            r_out,
    output logic [NREQ-1:0] grant,
    output logic            done,
    output logic            err,
    output logic            busy
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   win_idx_nxt;
    logic            op_lat;
    logic            op_lat_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_nxt;
    logic [IW-1:0]   pick;
    logic            s_nxt;
    logic            r_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic            done_nxt;
    logic            err_nxt;
    logic            busy_nxt;

    // First requesting index at or after p, wrapping modulo NREQ.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   p);
        logic [IW-1:0] win;
        logic          found;
        int            idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(p) + i) % NREQ;
            if (!found && r[idx]) begin
                win   = IW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] w);
        return (w == IW'(NREQ - 1)) ? '0 : w + 1'b1;
    endfunction

    assign pick = rr_pick(req, ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            win_idx <= '0;
            op_lat  <= 1'b0;
            ptr     <= '0;
            s_out   <= 1'b0;
            r_out   <= 1'b0;
            grant   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            win_idx <= win_idx_nxt;
            op_lat  <= op_lat_nxt;
            ptr     <= ptr_nxt;
            s_out   <= s_nxt;
            r_out   <= r_nxt;
            grant   <= grant_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            busy    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = PULSE;
            PULSE:   if (cnt == '0) state_nxt = SETTLE;
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; S and R are only ever loaded from
    // complementary values of one latched bit, so they cannot both be high.
    always_comb begin
        cnt_nxt     = cnt;
        win_idx_nxt = win_idx;
        op_lat_nxt  = op_lat;
        ptr_nxt     = ptr;
        s_nxt       = 1'b0;
        r_nxt       = 1'b0;
        grant_nxt   = grant;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                grant_nxt = '0;
                if (|req) begin
                    win_idx_nxt = pick;
                    op_lat_nxt  = op[pick];
                    grant_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    s_nxt       = op[pick];
                    r_nxt       = ~op[pick];
                    cnt_nxt     = CW'(PULSE_CYCLES - 1);
                end
            end
            PULSE: begin
                if (cnt != '0) begin
                    s_nxt   = s_out;
                    r_nxt   = r_out;
                    cnt_nxt = cnt - 1'b1;
                end
            end
            SETTLE: begin
                done_nxt  = 1'b1;
                err_nxt   = (q_in != op_lat);
                ptr_nxt   = wrap_inc(win_idx);
                grant_nxt = '0;
            end
            default: begin
                grant_nxt = '0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: doc/srff_access_arbiter.md
Name: srff_access_arbiter

Overview:
- Round-robin controller that shares one clocked S-R flip-flop (srff_clk) among NREQ requesters.
- Each requester asks to set or reset the flip-flop. The block serialises the requests and generates clean S/R pulses, so the forbidden S=R=1 input is never produced.
- After each pulse it checks Q and reports completion or a mismatch. It sits directly between the requester logic and the srff_clk instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- PULSE_CYCLES, 1, number of clk cycles S or R is held high per operation (1..15)
- CW, 4, width of the pulse counter; must satisfy 2^CW > PULSE_CYCLES

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  request per requester; level, held until that requester's done
- op  input  NREQ  per-requester operation: 1 = set (S), 0 = reset (R); sampled at grant
- q_in  input  1  Q output fed back from srff_clk
- s_out  output  1  S input to srff_clk
- r_out  output  1  R input to srff_clk
- grant  output  NREQ  one-hot owner of the current operation; 0 when idle
- done  output  1  one-cycle pulse when the operation completes
- err  output  1  one-cycle pulse, coincident with done, when q_in != the latched op
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, s_out=0, r_out=0, grant=0, done=0, err=0, busy=0, rr pointer=0, pulse counter=0.
- All outputs are registered. The invariant s_out & r_out == 0 holds in every cycle.
- FSM has three states: IDLE, PULSE, SETTLE.
- IDLE:
  - done, err and grant are all 0.
  - If any req bit is set at a clock edge, choose the winner by round-robin: the first set bit at index >= ptr, wrapping modulo NREQ.
  - Latch the winner index and op[winner]. Set grant = one-hot(winner).
  - Drive s_out = op or r_out = ~op. Load counter = PULSE_CYCLES-1. Go to PULSE.
- PULSE:
  - s_out/r_out are held. When counter==0, clear s_out and r_out and go to SETTLE; otherwise decrement counter.
- SETTLE:
  - s_out = r_out = 0.
  - At the edge leaving SETTLE, sample q_in. Assert done=1 for one cycle and assert err=1 if q_in != latched op.
  - Set ptr = (winner+1) mod NREQ. Clear grant. Return to IDLE.
  - done and err are therefore visible during the first IDLE cycle.
- Latency: a request seen at edge k gives S/R high over [k+1, k+1+PULSE_CYCLES) and done high over [k+2+PULSE_CYCLES, k+3+PULSE_CYCLES).
- Back-to-back operation: if req is still pending in the IDLE cycle where done is high, a new grant is issued at that edge. Minimum period per operation is PULSE_CYCLES+2 cycles.
- Fairness: a requester holding req is granted within NREQ operations. The winner of the last operation has the lowest priority in the next arbitration.
- Simultaneous requests: one winner per arbitration. Losing requests stay pending; no state is lost.
- req dropped mid-operation: ignored. The operation completes and done/err are still generated.
- op changed mid-operation: ignored, because op is latched at grant.
- Redundant operation (set while Q=1): still pulsed; err=0 if Q stays 1.
- Reset mid-operation: s_out/r_out drop immediately, with no done and no err. ptr returns to 0.
- Reset values: all outputs 0 out of reset.

Test Plan:
- Reset then single request: rst pulse, then req=0001, op=0001 -> grant=0001 and s_out=1 for 1 cycle; 2 cycles later done=1, err=0, and q_in from srff_clk=1. r_out stays 0 throughout.
- Reset operation: from Q=1, req=0100, op=0000 -> grant=0100, r_out=1 for PULSE_CYCLES cycles, Q goes to 0, done=1, err=0.
- Round-robin: req=1111 held, ops alternating set/reset -> grant sequence 0001, 0010, 0100, 1000, 0001. Each operation takes 3 cycles. s_out & r_out never both 1 (assertion every cycle).
- Error detect: force q_in=0 while granting a set -> done=1 and err=1 in the same cycle; next arbitration proceeds normally.
- Reset mid-pulse: with PULSE_CYCLES=4, assert rst in the 2nd pulse cycle -> s_out=0 immediately, grant=0, no done pulse. After release, ptr=0 and req=1010 grants 0010 first.
- Request withdrawal and latching: req[2] drops and op[2] flips one cycle after grant -> the operation completes with the original op, done=1, and the next grant goes to the next pending requester.
